tone_decoder: RTL

//  Receive end of the speaker tone path: measures the period of an incoming square-wave tone
//  (PMOD input, e.g. a loopback of the PWM tone pin) and decodes it into a note code.

---
 rtl/tone_decoder_pkg.sv | 57 +++++
 rtl/tone_decoder_edge_sync.sv | 43 ++++
 rtl/tone_decoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tone_decoder_pkg.sv
// -----------------------------------------------------------------------------
// tone_pkg
//   Shared definitions for the tone path. The tone decoder and the music ROM
//   modules both use them.
//   - note_e            : note codes (NOTE_NONE = 0, NOTE_C4 = 1 .. NOTE_B5 = 14)
//   - note_centi_hz()   : note frequency table, in units of 0.01 Hz
//   - nominal_period()  : nominal tone period in clock cycles, rounded
//   - tone_state_e      : decoder measurement FSM states
// -----------------------------------------------------------------------------
package tone_pkg;

  typedef enum logic [3:0] {
    NOTE_NONE = 4'd0,
    NOTE_C4, NOTE_D4, NOTE_E4, NOTE_F4, NOTE_G4, NOTE_A4, NOTE_B4,
    NOTE_C5, NOTE_D5, NOTE_E5, NOTE_F5, NOTE_G5, NOTE_A5, NOTE_B5
  } note_e;

  localparam int unsigned NOTE_COUNT = 14;

  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } tone_state_e;

  // Centi-Hz keeps the non-integer note frequencies exact enough for rounding.
  function automatic int unsigned note_centi_hz(input note_e code);
    case (code)
      NOTE_C4: return 26163;
      NOTE_D4: return 29366;
      NOTE_E4: return 32963;
      NOTE_F4: return 34923;
      NOTE_G4: return 39200;
      NOTE_A4: return 44000;
      NOTE_B4: return 49388;
      NOTE_C5: return 52325;
      NOTE_D5: return 58733;
      NOTE_E5: return 65925;
      NOTE_F5: return 69846;
      NOTE_G5: return 78399;
      NOTE_A5: return 88000;
      NOTE_B5: return 98777;
      default: return 0;
    endcase
  endfunction

  // round(clk_freq / note_hz). Intended for elaboration-time constants only.
  function automatic logic [31:0] nominal_period(input int unsigned clk_freq,
                                                 input note_e       code);
    logic [63:0] chz;
    logic [63:0] num;
    chz = 64'(note_centi_hz(code));
    if (chz == '0) return '0;
    num = 64'(clk_freq) * 64'd100 + (chz >> 1);
    return 32'(num / chz);
  endfunction

endpackage

// File: rtl/tone_decoder_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
//   Two-flop synchronizer followed by a registered rising-edge detector.
//   Use it for any asynchronous level input, such as buttons or PMOD pins.
//   o_pulse is high for one cycle, three clocks after the input is first
//   sampled high.
// Ports
//   i_clk    in  1  clock
//   i_rst_n  in  1  asynchronous active-low reset
//   i_async  in  1  asynchronous input
//   o_pulse  out 1  one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_pulse;

  // The chain resets high, so a pin that is already high at reset release is
  // not reported as a rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_prev  <= 1'b1;
      r_pulse <= 1'b0;
    end else begin
      r_meta  <= i_async;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_pulse <= r_sync & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/tone_decoder.sv
// -----------------------------------------------------------------------------
// tone_decoder
//   Measures the period of a square-wave tone on a PMOD pin. It decodes the
//   period into a note code, and it reports silence when no rising edge
//   arrives for TIMEOUT_CYC cycles.
//   Latency is 4 clocks from a pin rising edge to note_valid:
//   2 synchronizer flops, 1 edge register and 1 classify register.
//
// Parameters
//   CLK_FREQ     clock frequency in Hz; the nominal note periods derive from it
//   TIMEOUT_CYC  cycles without a rising edge before silence is declared
//   TOL_SHIFT    a note matches when |period - nominal| <= nominal >> TOL_SHIFT
//
// Optional feature, macro PERIOD_AVG_EN
//   When defined, the decoder reports and classifies the mean of the last
//   4 captured periods. Strobes for captured periods are held back until
//   4 periods have been captured since the last IDLE.
//
// Ports
//   clk         in   1   system clock
//   reset       in   1   asynchronous active-low reset
//   pmod_in     in   1   asynchronous square-wave input
//   period      out  32  last reported period, in clk cycles
//   note_code   out  4   0 = none/unknown, 1..14 = C4..B5
//   note_match  out  1   period is within tolerance of note_code's nominal period
//   note_valid  out  1   one-cycle strobe: period/note_code/note_match updated
//   silent      out  1   high while silent (reset, or timeout)
// -----------------------------------------------------------------------------
module tone_decoder
  import tone_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned TOL_SHIFT   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pmod_in,
  output logic [31:0] period,
  output logic [3:0]  note_code,
  output logic        note_match,
  output logic        note_valid,
  output logic        silent
);

  logic              w_edge;
  tone_state_e       r_state;
  tone_state_e       w_state_nxt;
  logic [31:0]       r_cnt;
  logic              w_capture;
  logic              w_timeout;
  logic              w_cnt_expired;
  logic [31:0]       w_meas;
  logic              w_avg_ready;
  logic [NOTE_COUNT:1] w_in_tol;
  logic [3:0]        w_cls_code;
  logic              w_cls_match;

  logic [31:0]       r_period;
  logic [3:0]        r_note_code;
  logic              r_note_match;
  logic              r_note_valid;
  logic              r_silent;

  edge_sync u_edge_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_async (pmod_in),
    .o_pulse (w_edge)
  );

  // ---------------------------------------------------------------------------
  // Period counter: restarts at 1 on each edge and saturates at TIMEOUT_CYC.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= 32'd1;
    end else if (r_cnt < TIMEOUT_CYC) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  assign w_cnt_expired = (r_cnt >= TIMEOUT_CYC);

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_edge) w_state_nxt = ST_ARMED;
      ST_ARMED: if (!w_edge && w_cnt_expired) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // When an edge and an expired count arrive in the same cycle, the edge wins.
  always_comb begin
    w_capture = 1'b0;
    w_timeout = 1'b0;
    if (r_state == ST_ARMED) begin
      w_capture = w_edge;
      w_timeout = !w_edge && w_cnt_expired;
    end
  end

  // ---------------------------------------------------------------------------
  // Measured period: raw count, or the 4-entry running mean
  // ---------------------------------------------------------------------------
`ifdef PERIOD_AVG_EN
  logic [31:0] r_hist [3];
  logic [2:0]  r_fill;
  logic [33:0] w_sum;

  // The three older periods plus the one being captured now form the window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist[0] <= '0;
      r_hist[1] <= '0;
      r_hist[2] <= '0;
      r_fill    <= '0;
    end else if (r_state == ST_IDLE) begin
      r_fill <= '0;
    end else if (w_capture) begin
      r_hist[0] <= r_cnt;
      r_hist[1] <= r_hist[0];
      r_hist[2] <= r_hist[1];
      if (r_fill != 3'd4) r_fill <= r_fill + 3'd1;
    end
  end

  assign w_sum       = 34'(r_cnt) + 34'(r_hist[0]) + 34'(r_hist[1]) + 34'(r_hist[2]);
  assign w_meas      = 32'(w_sum >> 2);
  assign w_avg_ready = (r_fill >= 3'd3);
`else
  assign w_meas      = r_cnt;
  assign w_avg_ready = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Classifier: tolerance test against every nominal period in parallel
  // ---------------------------------------------------------------------------
  for (genvar g = 1; g <= NOTE_COUNT; g++) begin : g_note
    localparam logic [31:0] NOM = nominal_period(CLK_FREQ, note_e'(4'(g)));
    localparam logic [31:0] TOL = NOM >> TOL_SHIFT;
    logic [31:0] w_diff;
    assign w_diff      = (w_meas >= NOM) ? (w_meas - NOM) : (NOM - w_meas);
    assign w_in_tol[g] = (w_diff <= TOL);
  end

  // Adjacent tolerance windows overlap slightly, so the lowest code wins.
  always_comb begin
    w_cls_code  = NOTE_NONE;
    w_cls_match = 1'b0;
    for (int unsigned i = 1; i <= NOTE_COUNT; i++) begin
      if (!w_cls_match && w_in_tol[i]) begin
        w_cls_code  = 4'(i);
        w_cls_match = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_period     <= '0;
      r_note_code  <= NOTE_NONE;
      r_note_match <= 1'b0;
      r_note_valid <= 1'b0;
      r_silent     <= 1'b1;
    end else begin
      r_note_valid <= 1'b0;
      if (w_capture && w_avg_ready) begin
        r_period     <= w_meas;
        r_note_code  <= w_cls_code;
        r_note_match <= w_cls_match;
        r_note_valid <= 1'b1;
        r_silent     <= 1'b0;
      end else if (w_timeout) begin
        r_note_code  <= NOTE_NONE;
        r_note_match <= 1'b0;
        r_note_valid <= 1'b1;
        r_silent     <= 1'b1;
      end
    end
  end

  assign period     = r_period;
  assign note_code  = r_note_code;
  assign note_match = r_note_match;
  assign note_valid = r_note_valid;
  assign silent     = r_silent;

endmodule
